// File: rtl/prom_loader.sv
// rtl/prom_loader.sv - UART-fed PROM loader: SYNC/START/LEN/payload[/CSUM] frames written into an async-read PROM
// Optional checksum byte and accumulator: define PROM_LOADER_CHECKSUM_EN
module prom_loader #(
  parameter int WORD_BITS = 16,
  parameter int ROM_WORDS = 8,
  localparam int AW = $clog2(ROM_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_ready_i,
  output logic                 rx_ack_o,
  input  logic [AW-1:0]        read_addr_i,
  output logic [WORD_BITS-1:0] read_data_o,
  output logic                 load_done_o,
  output logic                 error_o,
  output logic [AW-1:0]        write_addr_o
);

  localparam int WORD_BYTES = WORD_BITS / 8;
  localparam int BIW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BIW-1:0] LAST_IDX = BIW'(WORD_BYTES - 1);
  localparam logic [7:0] SYNC_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LEN,
    S_DATA,
`ifdef PROM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [BIW-1:0]       idx_q, idx_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [WORD_BITS-1:0] asm_q, asm_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 prom_we;
`ifdef PROM_LOADER_CHECKSUM_EN
  logic [7:0]           acc_q, acc_d;
`endif

  logic [WORD_BITS-1:0] prom [ROM_WORDS];

  assign rx_ack_o     = rx_ready_i;
  assign read_data_o  = prom[read_addr_i];
  assign load_done_o  = done_q;
  assign error_o      = err_q;
  assign write_addr_o = ptr_q;

  // State and datapath registers; PROM is deliberately outside reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROM_LOADER_CHECKSUM_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef PROM_LOADER_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Frame parser: next state, pointer/counter updates and PROM write strobe
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    done_d  = done_q;
    err_d   = err_q;
    prom_we = 1'b0;
`ifdef PROM_LOADER_CHECKSUM_EN
    acc_d   = acc_q;
`endif
    if (rx_ready_i) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (rx_data_i == SYNC_BYTE) begin
            state_d = S_START;
            done_d  = 1'b0;
            err_d   = 1'b0;
`ifdef PROM_LOADER_CHECKSUM_EN
            acc_d   = '0;
`endif
          end
        end
        S_START: begin
          ptr_d   = rx_data_i[AW-1:0];
          idx_d   = '0;
          state_d = S_LEN;
`ifdef PROM_LOADER_CHECKSUM_EN
          acc_d   = acc_q + rx_data_i;
`endif
        end
        S_LEN: begin
          if (rx_data_i == 8'd0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = rx_data_i;
            state_d = S_DATA;
`ifdef PROM_LOADER_CHECKSUM_EN
            acc_d   = acc_q + rx_data_i;
`endif
          end
        end
        S_DATA: begin
          asm_d[{idx_q, 3'b000} +: 8] = rx_data_i;
`ifdef PROM_LOADER_CHECKSUM_EN
          acc_d = acc_q + rx_data_i;
`endif
          if (idx_q == LAST_IDX) begin
            // The completed word (asm_d) is written on this same edge
            prom_we = 1'b1;
            ptr_d   = ptr_q + AW'(1);
            cnt_d   = cnt_q - 8'd1;
            idx_d   = '0;
            if (cnt_q == 8'd1) begin
`ifdef PROM_LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
              done_d  = 1'b1;
`endif
            end
          end else begin
            idx_d = idx_q + BIW'(1);
          end
        end
`ifdef PROM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (8'(acc_q + rx_data_i) == 8'd0) done_d = 1'b1;
          else                               err_d  = 1'b1;
          state_d = S_DONE;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // PROM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (prom_we) prom[ptr_q] <= asm_d;
  end

endmodule
